// File: rtl/melody_sequencer.sv
// Programmable square-wave melody player: steps through a RAM note table (half-period, duration),
// with rests, an inter-note gap, one-shot or looped playback, and start/stop control.
module melody_sequencer #(
   parameter int NUM_NOTES = 32,
   parameter int HP_W      = 20,
   parameter int DUR_W     = 12,
   parameter int TICK_DIV  = 50000,
   parameter int GAP_TICKS = 10,
   localparam int AW       = $clog2(NUM_NOTES)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [HP_W-1:0]  wr_half_per,
   input  logic [DUR_W-1:0] wr_dur,
   input  logic             start,
   input  logic             stop,
   input  logic             loop_mode,
   output logic             sound,
   output logic             busy,
   output logic             done,
   output logic [AW-1:0]    note_idx
);

   localparam int TW      = $clog2(TICK_DIV);
   localparam int GAP_CYC = GAP_TICKS * TICK_DIV;
   localparam int GW      = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);
   localparam logic [AW-1:0] IDX_LAST  = AW'(NUM_NOTES - 1);

   typedef enum logic [2:0] {IDLE, LOAD, PLAY, GAP, DONE} state_t;

   state_t           state;
   logic [HP_W-1:0]  hp;
   logic [DUR_W-1:0] rem;
   logic [HP_W-1:0]  tone_cnt;
   logic [TW-1:0]    tick_cnt;
   logic [GW-1:0]    gap_cnt;
   logic             loop_lat;

   logic [HP_W-1:0]  hp_tbl  [NUM_NOTES];
   logic [DUR_W-1:0] dur_tbl [NUM_NOTES];

   logic             adv_done;
   logic [AW-1:0]    adv_idx;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         hp_tbl[wr_addr]  <= wr_half_per;
         dur_tbl[wr_addr] <= wr_dur;
      end
   end

   // The last table slot acts as an implicit end-of-song once its note and gap finish.
   always_comb begin
      adv_done = (note_idx == IDX_LAST) && !loop_lat;
      adv_idx  = (note_idx == IDX_LAST) ? '0 : note_idx + AW'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         hp       <= '0;
         rem      <= '0;
         tone_cnt <= '0;
         tick_cnt <= '0;
         gap_cnt  <= '0;
         loop_lat <= 1'b0;
         sound    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         note_idx <= '0;
      end else if (stop && state != IDLE) begin
         state <= IDLE;
         sound <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start && !stop) begin
                  state    <= LOAD;
                  note_idx <= '0;
                  busy     <= 1'b1;
               end
            end
            LOAD: begin
               hp       <= hp_tbl[note_idx];
               rem      <= dur_tbl[note_idx];
               tone_cnt <= '0;
               tick_cnt <= '0;
               gap_cnt  <= '0;
               sound    <= 1'b0;
               loop_lat <= loop_mode;
               if (dur_tbl[note_idx] == '0) begin
                  // An end marker in slot 0 would loop forever without playing anything.
                  if (loop_mode && note_idx != '0) begin
                     note_idx <= '0;
                  end else begin
                     state <= DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  state <= PLAY;
               end
            end
            PLAY: begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  rem      <= rem - DUR_W'(1);
               end else begin
                  tick_cnt <= tick_cnt + TW'(1);
               end
               if (hp != '0) begin
                  if (tone_cnt == hp - HP_W'(1)) begin
                     sound    <= ~sound;
                     tone_cnt <= '0;
                  end else begin
                     tone_cnt <= tone_cnt + HP_W'(1);
                  end
               end
               if (tick_cnt == TICK_LAST && rem == DUR_W'(1)) begin
                  sound   <= 1'b0;
                  gap_cnt <= '0;
                  if (GAP_CYC > 0) begin
                     state <= GAP;
                  end else begin
                     state    <= adv_done ? DONE : LOAD;
                     done     <= adv_done;
                     note_idx <= adv_done ? note_idx : adv_idx;
                  end
               end
            end
            GAP: begin
               if (gap_cnt == GAP_LAST) begin
                  state    <= adv_done ? DONE : LOAD;
                  done     <= adv_done;
                  note_idx <= adv_done ? note_idx : adv_idx;
               end else begin
                  gap_cnt <= gap_cnt + GW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               sound <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
